// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled sclk/ss/mosi, one-byte RX strobe, single-entry TX holding buffer.
module spi_slave #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_full,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q,   ss_prev_d;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic                   tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   miso_q, miso_d;
    logic                   tx_underrun_q, tx_underrun_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic reload;

    // Input synchronizer chains plus one delayed copy of sclk/ss for edge detection.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        ss_rise     = ss_s & ~ss_prev_q;
        ss_fall     = ~ss_s & ss_prev_q;
    end

    // Frame FSM, shifters, holding buffer and registered outputs.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        tx_full_d     = tx_full_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        reload        = 1'b0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d = ACTIVE;
                    reload  = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    // Deselect wins over a coincident sclk edge; partial byte is dropped.
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        reload = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Byte boundary: take the buffered byte, or the fill pattern on underrun.
        if (reload) begin
            if (tx_full_q) begin
                tx_shift_d = hold_q;
            end else begin
                tx_shift_d    = IDLE_FILL;
                tx_underrun_d = 1'b1;
            end
            tx_full_d = 1'b0;
        end

        // Loads are judged against the registered flag, so a same-cycle reload still underruns.
        if (tx_load && !tx_full_q) begin
            hold_d    = tx_data;
            tx_full_d = 1'b1;
        end

        busy_d = (state_d == ACTIVE);
        miso_d = busy_d & tx_shift_d[DATA_WIDTH-1];
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q   <= '0;
            ss_sync_q     <= '0;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            ss_prev_q     <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            hold_q        <= '0;
            tx_full_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            ss_sync_q     <= ss_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            ss_prev_q     <= ss_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            tx_full_q     <= tx_full_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            busy_q        <= busy_d;
            miso_q        <= miso_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign miso        = miso_q;
    assign tx_full     = tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = busy_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed plus random SPI sessions against a byte-level reference model.
module tb_spi_slave;

    localparam int unsigned W     = 8;
    localparam int          H     = 10;
    localparam logic [7:0]  FILL  = 8'h00;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         ss;
    logic         mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_load;
    logic         tx_full;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         tx_underrun;

    spi_slave #(
        .DATA_WIDTH (W),
        .SYNC_STAGES(2),
        .IDLE_FILL  (FILL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_full    (tx_full),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Observed pulse-cycle counts and their model expectations.
    int rxv_cnt = 0;
    int und_cnt = 0;
    int exp_rxv = 0;
    int exp_und = 0;

    // Reference model: holding buffer, last received byte, byte being shifted out.
    logic [7:0] m_hold = 8'h00;
    bit         m_full = 1'b0;
    logic [7:0] m_rx   = 8'h00;
    logic [7:0] cur_tx = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Pulse-cycle counters: a stretched strobe shows up as an extra count.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_valid)    rxv_cnt++;
            if (tx_underrun) und_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reload();
        if (m_full) begin
            cur_tx = m_hold;
            m_full = 1'b0;
        end else begin
            cur_tx = FILL;
            exp_und++;
        end
    endtask

    task automatic load(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (!m_full) begin
            m_hold = d;
            m_full = 1'b1;
        end
    endtask

    task automatic ss_fall();
        ss = 1'b0;
        model_reload();
        wait_clk(H);
        chk("busy_on", 32'(busy), 32'd1);
        chk("tx_full_start", 32'(tx_full), 32'(m_full));
    endtask

    task automatic ss_rise();
        wait_clk(H);
        ss = 1'b1;
        wait_clk(H);
        chk("busy_off", 32'(busy), 32'd0);
        chk("miso_idle", 32'(miso), 32'd0);
        chk("rx_valid_cnt", 32'(rxv_cnt), 32'(exp_rxv));
        chk("underrun_cnt", 32'(und_cnt), 32'(exp_und));
        chk("rx_data", 32'(rx_data), 32'(m_rx));
        chk("tx_full_end", 32'(tx_full), 32'(m_full));
    endtask

    // One byte (or a truncated one) in mode 0; miso sampled just before each rise.
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_load, input logic [7:0] ld);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            wait_clk(H);
            got[7-i] = miso;
            sclk = 1'b1;
            if (do_load && i == 3) begin
                wait_clk(H - 2);
                load(ld);
            end else begin
                wait_clk(H);
            end
            sclk = 1'b0;
        end
        if (nbits == 8) begin
            chk("miso_byte", 32'(got), 32'(cur_tx));
            exp_rxv++;
            m_rx = mo;
            model_reload();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({miso, tx_full, busy, rx_valid, tx_underrun, rx_data}), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        sclk    = 1'b0;
        ss      = 1'b1;
        mosi    = 1'b0;
        tx_load = 1'b0;
        tx_data = '0;

        // Reset with every input toggling.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk_all_zero("reset_outs");
            sclk    = 1'($urandom);
            ss      = 1'($urandom);
            mosi    = 1'($urandom);
            tx_load = 1'($urandom);
            tx_data = 8'($urandom);
        end
        sclk    = 1'b0;
        ss      = 1'b1;
        mosi    = 1'b0;
        tx_load = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
        chk_all_zero("post_reset");

        // Preloaded byte, single frame.
        load(8'hA5);
        wait_clk(2);
        chk("tx_full_preload", 32'(tx_full), 32'd1);
        ss_fall();
        xfer(8'h13, 8, 1'b0, 8'h00);
        ss_rise();

        // Back-to-back bytes with a reload during the first.
        load(8'h5A);
        ss_fall();
        xfer(8'h13, 8, 1'b1, 8'h3C);
        xfer(8'h14, 8, 1'b0, 8'h00);
        ss_rise();

        // Empty buffer at frame start, then a load attempted while full.
        ss_fall();
        xfer(8'h9B, 8, 1'b0, 8'h00);
        ss_rise();
        load(8'h55);
        load(8'h77);
        wait_clk(2);
        chk("tx_full_kept", 32'(tx_full), 32'd1);
        ss_fall();
        xfer(8'h20, 8, 1'b0, 8'h00);
        ss_rise();

        // Abort after 4 bits, then a clean frame.
        load(8'hC3);
        ss_fall();
        xfer(8'hF0, 4, 1'b0, 8'h00);
        ss_rise();
        ss_fall();
        xfer(8'h6E, 8, 1'b0, 8'h00);
        ss_rise();

        // Reset mid-frame after 5 bits, then a fresh frame.
        load(8'h99);
        ss_fall();
        xfer(8'hAA, 5, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        chk_all_zero("midframe_reset");
        ss = 1'b1;
        wait_clk(3);
        rst    = 1'b0;
        m_full = 1'b0;
        m_hold = 8'h00;
        m_rx   = 8'h00;
        wait_clk(6);
        chk_all_zero("post_midframe_reset");
        ss_fall();
        xfer(8'h81, 8, 1'b0, 8'h00);
        ss_rise();

        // Random sessions: random preload, 1-3 bytes, occasional mid-byte reload or abort.
        for (int s = 0; s < 10; s++) begin
            int nb;
            if ($urandom_range(1) == 1) load(8'($urandom));
            nb = int'($urandom_range(3, 1));
            ss_fall();
            for (int b = 0; b < nb; b++) begin
                int nbits;
                bit ld_en;
                nbits = 8;
                if (b == nb - 1 && $urandom_range(3) == 0) nbits = int'($urandom_range(7, 1));
                ld_en = ($urandom_range(1) == 1);
                xfer(8'($urandom), nbits, ld_en, 8'($urandom));
            end
            ss_rise();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
